systolic_seq_ctrl: RTL and testbench

//   Host-side sequencer for the 8x8 systolic array top-level wrapper. Runs one

---
 rtl/systolic_seq_ctrl_if.sv | 25 ++
 rtl/systolic_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Operand input stream and result output stream between the host and the
// systolic-array sequencer.
interface systolic_seq_ctrl_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_idx;

  // host side: produces operands, consumes results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  // sequencer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Host-side sequencer for the 8x8 systolic array wrapper. One pass per start:
// clear -> load B -> load A -> shift -> drain bottom partial sums -> done.
module systolic_seq_ctrl #(
  parameter int DW           = 16,
  parameter int B_WORDS      = 64,
  parameter int A_WORDS      = 8,
  parameter int PS_COLS      = 8,
  parameter int SHIFT_CYCLES = 15
) (
  input  logic           Clock,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  systolic_seq_ctrl_if.slave s,
  output logic           arr_data_clear,
  output logic           arr_en_shift_right,
  output logic           arr_en_shift_bottom,
  output logic           arr_we,
  output logic           arr_sel_a_or_b,
  output logic [7:0]     arr_b_sel,
  output logic [2:0]     arr_a_sel,
  output logic [DW-1:0]  arr_wdata,
  output logic [2:0]     arr_ps_sel,
  input  logic [DW-1:0]  arr_ps_in
);

  localparam int BW = (B_WORDS      > 1) ? $clog2(B_WORDS)      : 1;
  localparam int AW = (A_WORDS      > 1) ? $clog2(A_WORDS)      : 1;
  localparam int SW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int PW = (PS_COLS      > 1) ? $clog2(PS_COLS)      : 1;

  localparam logic [BW-1:0] B_LAST = BW'(B_WORDS - 1);
  localparam logic [AW-1:0] A_LAST = AW'(A_WORDS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SHIFT_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PS_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_B, LOAD_A, SHIFT, DRAIN, DONE
  } state_t;

  state_t        state, nxt;
  logic [BW-1:0] b_cnt;
  logic [AW-1:0] a_cnt;
  logic [SW-1:0] s_cnt;
  logic [PW-1:0] p_cnt;
  logic          beat, acc;

  assign beat = s.in_valid & s.in_ready;
  assign acc  = s.out_valid & s.out_ready;

  // state register
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state and output decode; everything idles at 0 outside its phase
  always_comb begin
    nxt                 = state;
    busy                = 1'b0;
    done                = 1'b0;
    s.in_ready          = 1'b0;
    s.out_valid         = 1'b0;
    s.out_data          = '0;
    s.out_idx           = '0;
    arr_data_clear      = 1'b0;
    arr_en_shift_right  = 1'b0;
    arr_en_shift_bottom = 1'b0;
    arr_we              = 1'b0;
    arr_sel_a_or_b      = 1'b0;
    arr_b_sel           = '0;
    arr_a_sel           = '0;
    arr_wdata           = '0;
    arr_ps_sel          = '0;
    case (state)
      IDLE: if (start) nxt = CLEAR;
      CLEAR: begin
        busy           = 1'b1;
        arr_data_clear = 1'b1;
        nxt            = LOAD_B;
      end
      LOAD_B: begin
        busy       = 1'b1;
        s.in_ready = 1'b1;
        arr_we     = s.in_valid;
        arr_wdata  = s.in_data;
        arr_b_sel  = 8'(b_cnt);
        if (s.in_valid && b_cnt == B_LAST) nxt = LOAD_A;
      end
      LOAD_A: begin
        busy           = 1'b1;
        s.in_ready     = 1'b1;
        arr_we         = s.in_valid;
        arr_wdata      = s.in_data;
        arr_sel_a_or_b = 1'b1;
        arr_a_sel      = 3'(a_cnt);
        if (s.in_valid && a_cnt == A_LAST) nxt = SHIFT;
      end
      SHIFT: begin
        busy                = 1'b1;
        arr_en_shift_right  = 1'b1;
        arr_en_shift_bottom = 1'b1;
        if (s_cnt == S_LAST) nxt = DRAIN;
      end
      DRAIN: begin
        busy        = 1'b1;
        s.out_valid = 1'b1;
        arr_ps_sel  = 3'(p_cnt);
        s.out_idx   = 3'(p_cnt);
        s.out_data  = arr_ps_in;
        if (s.out_ready && p_cnt == P_LAST) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // phase counters: advance on handshake, return to 0 when their phase ends
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt <= '0;
      a_cnt <= '0;
      s_cnt <= '0;
      p_cnt <= '0;
    end else if (abort || state == CLEAR) begin
      b_cnt <= '0;
      a_cnt <= '0;
      s_cnt <= '0;
      p_cnt <= '0;
    end else begin
      if (state == LOAD_B && beat) b_cnt <= (b_cnt == B_LAST) ? '0 : b_cnt + 1'b1;
      if (state == LOAD_A && beat) a_cnt <= (a_cnt == A_LAST) ? '0 : a_cnt + 1'b1;
      if (state == SHIFT)          s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
      if (state == DRAIN && acc)   p_cnt <= (p_cnt == P_LAST) ? '0 : p_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl; array partial sums modelled as
// 0x100 + ps_sel.
module tb_systolic_seq_ctrl;
  localparam int DW = 16;
  localparam int BN = 64;
  localparam int AN = 8;

  logic          Clock, rst_n, start, abort, busy, done;
  logic          arr_data_clear, arr_en_shift_right, arr_en_shift_bottom;
  logic          arr_we, arr_sel_a_or_b;
  logic [7:0]    arr_b_sel;
  logic [2:0]    arr_a_sel, arr_ps_sel;
  logic [DW-1:0] arr_wdata, arr_ps_in;
  int            n_chk, n_fail, cyc;

  systolic_seq_ctrl_if #(.DW(DW)) sif();

  systolic_seq_ctrl dut (
    .Clock(Clock), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .s(sif.slave),
    .arr_data_clear(arr_data_clear), .arr_en_shift_right(arr_en_shift_right),
    .arr_en_shift_bottom(arr_en_shift_bottom), .arr_we(arr_we),
    .arr_sel_a_or_b(arr_sel_a_or_b), .arr_b_sel(arr_b_sel), .arr_a_sel(arr_a_sel),
    .arr_wdata(arr_wdata), .arr_ps_sel(arr_ps_sel), .arr_ps_in(arr_ps_in)
  );

  assign arr_ps_in = 16'h0100 + {13'd0, arr_ps_sel};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // every output at 0 (reset / idle decode)
  task automatic chk_zero(input string tag);
    chk(tag, {busy, done, sif.in_ready, sif.out_valid, sif.out_data, sif.out_idx,
              arr_data_clear, arr_en_shift_right, arr_en_shift_bottom, arr_we,
              arr_sel_a_or_b, arr_b_sel, arr_a_sel, arr_wdata, arr_ps_sel}, 64'd0);
  endtask

  // one full pass; tog: valid pattern 0,1,0,1 in LOAD_B; stall_idx: out_ready
  // low 5 cycles at that column; rst_idx: assert rst_n at that column and stop;
  // poke: pulse start during SHIFT and in DONE
  task automatic run_pass(input bit tog, input int stall_idx, input int rst_idx,
                          input bit poke, output int ncyc);
    int b, lb, idx, stl, n;
    sif.in_valid = 1'b0; sif.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0; ncyc = 1; #1;
    chk("clear", arr_data_clear, 1); chk("clear_busy", busy, 1);
    chk("clear_rdy", sif.in_ready, 0);
    tick(); ncyc++;
    b = 0; lb = 0;
    while (b < BN && lb < 4*BN) begin
      sif.in_valid = tog ? lb[0] : 1'b1;
      sif.in_data  = DW'(b + 1); #1;
      chk("b_rdy", sif.in_ready, 1); chk("b_ab", arr_sel_a_or_b, 0);
      chk("b_we", arr_we, sif.in_valid);
      if (sif.in_valid) begin
        chk("b_sel", arr_b_sel, b); chk("b_wdata", arr_wdata, b + 1); b++;
      end
      tick(); ncyc++; lb++;
    end
    chk("b_len", lb, tog ? 2*BN : BN);
    for (int a = 0; a < AN; a++) begin
      sif.in_valid = 1'b1; sif.in_data = DW'(BN + 1 + a); #1;
      chk("a_ab", arr_sel_a_or_b, 1); chk("a_sel", arr_a_sel, a);
      chk("a_we", arr_we, 1); chk("a_wdata", arr_wdata, BN + 1 + a);
      tick(); ncyc++;
    end
    sif.in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("sh_r", arr_en_shift_right, 1); chk("sh_b", arr_en_shift_bottom, 1);
      chk("sh_rdy", sif.in_ready, 0); chk("sh_ov", sif.out_valid, 0);
      if (poke && k == 5) start = 1'b1;
      tick(); start = 1'b0; ncyc++;
    end
    idx = 0; stl = 0; n = 0;
    while (idx < 8 && n < 64) begin
      sif.out_ready = !(idx == stall_idx && stl < 5); #1;
      chk("dr_ov", sif.out_valid, 1); chk("dr_idx", sif.out_idx, idx);
      chk("dr_ps_sel", arr_ps_sel, idx); chk("dr_data", sif.out_data, 16'h0100 + idx);
      chk("dr_shift", arr_en_shift_right, 0);
      if (idx == rst_idx) begin
        rst_n = 1'b0; #1;
        chk_zero("rst_async");
        return;
      end
      tick(); ncyc++; n++;
      if (sif.out_ready) idx++; else stl++;
    end
    if (stall_idx >= 0) chk("stall_len", stl, 5);
    #1;
    chk("done", done, 1); chk("done_busy", busy, 0); chk("done_ov", sif.out_valid, 0);
    if (poke) start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("done_pulse", done, 0); chk("post_busy", busy, 0); chk("post_clear", arr_data_clear, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    sif.in_valid = 1'b1; sif.in_data = 16'h1234; sif.out_ready = 1'b1;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    tick(); #1;
    chk_zero("idle");

    // 1: nominal pass, 97-cycle latency
    run_pass(1'b0, -1, -1, 1'b0, cyc);
    chk("latency", cyc, 97);

    // 2: in_valid toggling in LOAD_B
    run_pass(1'b1, -1, -1, 1'b0, cyc);
    chk("latency_tog", cyc, 97 + BN);

    // 3: sink stall at column 3
    run_pass(1'b0, 3, -1, 1'b0, cyc);
    chk("latency_stall", cyc, 102);

    // 4: abort at b_cnt == 20, then restart
    sif.in_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 20; i++) begin
      sif.in_data = DW'(i + 1); tick();
    end
    #1;
    chk("abort_bsel", arr_b_sel, 20);
    abort = 1'b1; tick(); abort = 1'b0; #1;
    chk("abort_busy", busy, 0); chk("abort_rdy", sif.in_ready, 0);
    chk("abort_we", arr_we, 0);
    run_pass(1'b0, -1, -1, 1'b0, cyc);
    chk("latency_reload", cyc, 97);

    // 5: start+abort in IDLE, then start pulses during SHIFT and DONE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0; #1;
    chk("sa_busy", busy, 0); chk("sa_clear", arr_data_clear, 0);
    run_pass(1'b0, -1, -1, 1'b1, cyc);
    chk("latency_poke", cyc, 97);

    // 6: reset during DRAIN
    run_pass(1'b0, -1, 2, 1'b0, cyc);
    #2; rst_n = 1'b1;
    repeat (5) tick();
    #1;
    chk_zero("post_rst_idle");
    run_pass(1'b0, -1, -1, 1'b0, cyc);
    chk("latency_post_rst", cyc, 97);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
